// File: rtl/edge_event_counter_pkg.sv
// Shared types and defaults for edge_event_counter.
// Optional snapshot parity output is enabled by EDGE_EVENT_COUNTER_PARITY_EN.
package edge_event_counter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_VALID = 1'b1
   } state_t;

   localparam int unsigned WIDTH_DEF = 32;
   localparam int unsigned SYNC_DEF  = 2;

endpackage

// File: rtl/edge_event_counter_sync_ff.sv
// Multi-flop synchronizer for one asynchronous bit; output is the last stage.
// Part of edge_event_counter (optional feature macro: EDGE_EVENT_COUNTER_PARITY_EN).
module sync_ff
   import edge_event_counter_pkg::*;
#(
   parameter int unsigned DEPTH = SYNC_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [DEPTH-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[DEPTH-2:0], i_d};
      end
   end

   assign o_q = r_sync[DEPTH-1];

endmodule

// File: rtl/edge_event_counter.sv
// Up/down event counter on rising edges of async input a, with valid/ready snapshot port.
// Define EDGE_EVENT_COUNTER_PARITY_EN to add the c_par snapshot parity output.
module edge_event_counter
   import edge_event_counter_pkg::*;
#(
   parameter int unsigned WIDTH       = WIDTH_DEF,
   parameter int unsigned SYNC_STAGES = SYNC_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             clr,
   input  logic             snap,
   output logic [WIDTH-1:0] c,
   output logic             c_valid,
   input  logic             c_ready,
   output logic             tc
`ifdef EDGE_EVENT_COUNTER_PARITY_EN
   ,
   output logic             c_par
`endif
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic             w_s_a;
   logic             w_s_b;
   logic             r_s_a_q;
   logic             w_edge;
   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_capture;
   logic [WIDTH-1:0] r_c;

   sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_a (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (a),
      .o_q   (w_s_a)
   );

   sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_b (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (b),
      .o_q   (w_s_b)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s_a_q <= 1'b0;
      end else begin
         r_s_a_q <= w_s_a;
      end
   end

   assign w_edge = w_s_a & ~r_s_a_q;

   // clr outranks a coincident edge; tc flags only the wrapping transition
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         r_tc    <= 1'b0;
      end else if (clr) begin
         r_count <= '0;
         r_tc    <= 1'b0;
      end else if (w_edge && w_s_b) begin
         r_count <= r_count + ONE;
         r_tc    <= &r_count;
      end else if (w_edge) begin
         r_count <= r_count - ONE;
         r_tc    <= ~|r_count;
      end else begin
         r_tc    <= 1'b0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (snap) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_VALID;
            end
         end
         ST_VALID: begin
            if (c_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_c     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_capture) begin
            r_c <= r_count;
         end
      end
   end

`ifdef EDGE_EVENT_COUNTER_PARITY_EN
   logic r_par;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_par <= 1'b0;
      end else if (w_capture) begin
         r_par <= ^r_count;
      end
   end

   assign c_par = r_par;
`endif

   assign c       = r_c;
   assign c_valid = (r_state == ST_VALID);
   assign tc      = r_tc;

endmodule

// File: tb/tb_edge_event_counter.sv
// Randomized self-checking bench for edge_event_counter against an event-level model.
// Parity checks are included when EDGE_EVENT_COUNTER_PARITY_EN is defined.
module tb_edge_event_counter;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         a;
   logic         b;
   logic         clr;
   logic         snap;
   logic [W-1:0] c;
   logic         c_valid;
   logic         c_ready;
   logic         tc;
`ifdef EDGE_EVENT_COUNTER_PARITY_EN
   logic         c_par;
`endif

   int unsigned  n_cmp     = 0;
   int unsigned  n_bad     = 0;
   int unsigned  tc_seen   = 0;
   int unsigned  tc_double = 0;
   logic         prev_tc   = 1'b0;
   logic [W-1:0] m_count;

   always #5 clk = ~clk;

   edge_event_counter #(
      .WIDTH       (W),
      .SYNC_STAGES (2)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a),
      .b       (b),
      .clr     (clr),
      .snap    (snap),
      .c       (c),
      .c_valid (c_valid),
      .c_ready (c_ready),
      .tc      (tc)
`ifdef EDGE_EVENT_COUNTER_PARITY_EN
      ,
      .c_par   (c_par)
`endif
   );

   always @(negedge clk) begin
      if (tc) tc_seen++;
      if (tc && prev_tc) tc_double++;
      prev_tc = tc;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One clean event; expected wrap comes from the carry/borrow of 33-bit arithmetic
   task automatic ev(input logic dir);
      logic [W:0]  res;
      int unsigned t0;
      res = dir ? ({1'b0, m_count} + 33'd1) : ({1'b0, m_count} - 33'd1);
      t0  = tc_seen;
      b = dir;
      cyc(1);
      a = 1'b1;
      cyc(1 + $urandom_range(0, 2));
      a = 1'b0;
      cyc(1 + $urandom_range(0, 2));
      cyc(3);
      m_count = res[W-1:0];
      chk("tc_per_event", 64'(tc_seen - t0), 64'(res[W]));
   endtask

   task automatic do_clr();
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
      m_count = '0;
   endtask

   task automatic snap_chk(input string tag, input int unsigned hold);
      chk({tag, "_pre_idle"}, 64'(c_valid), 64'd0);
      snap = 1'b1;
      cyc(1);
      snap = 1'b0;
      chk({tag, "_c"}, 64'(c), 64'(m_count));
      chk({tag, "_valid"}, 64'(c_valid), 64'd1);
`ifdef EDGE_EVENT_COUNTER_PARITY_EN
      chk({tag, "_par"}, 64'(c_par), 64'(^m_count));
`endif
      for (int i = 0; i < int'(hold); i++) begin
         snap = 1'($urandom_range(0, 1));
         cyc(1);
         chk({tag, "_hold_c"}, 64'(c), 64'(m_count));
         chk({tag, "_hold_valid"}, 64'(c_valid), 64'd1);
      end
      snap    = 1'b0;
      c_ready = 1'b1;
      cyc(1);
      c_ready = 1'b0;
      chk({tag, "_released"}, 64'(c_valid), 64'd0);
   endtask

   initial begin
      logic [W-1:0] held;
      int unsigned  t0;
      a = 1'b0; b = 1'b1; clr = 1'b0; snap = 1'b0; c_ready = 1'b0;
      rst_n = 1'b0;
      m_count = '0;
      cyc(2);
      chk("rst_c", 64'(c), 64'd0);
      chk("rst_valid", 64'(c_valid), 64'd0);
      chk("rst_tc", 64'(tc), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      cyc(2);
      snap_chk("rst_snap", 2);

      // count up 5, hold 10 cycles with snap toggling
      do_clr();
      for (int i = 0; i < 5; i++) ev(1'b1);
      snap_chk("up5", 10);
      snap_chk("back2back", 0);

      // wrap up through all-ones
      do_clr();
      for (int i = 0; i < 3; i++) ev(1'b0);
      snap_chk("down3", 1);
      for (int i = 0; i < 3; i++) ev(1'b1);
      snap_chk("wrap_up", 1);

      // wrap down from zero
      do_clr();
      ev(1'b0);
      snap_chk("wrap_down", 1);

      // clr coincident with an up edge: edge discarded
      do_clr();
      for (int i = 0; i < 3; i++) ev(1'b1);
      t0 = tc_seen;
      b = 1'b1; cyc(1);
      a = 1'b1; cyc(2);
      clr = 1'b1; cyc(1);
      clr = 1'b0; a = 1'b0; cyc(4);
      m_count = '0;
      chk("clr_edge_tc", 64'(tc_seen - t0), 64'd0);
      snap_chk("clr_edge", 1);

      // snap coincident with an edge captures the pre-edge count
      for (int i = 0; i < 2; i++) ev(1'b1);
      b = 1'b1; cyc(1);
      a = 1'b1; cyc(2);
      snap = 1'b1; cyc(1);
      snap = 1'b0;
      chk("snap_edge_c", 64'(c), 64'(m_count));
      chk("snap_edge_valid", 64'(c_valid), 64'd1);
      a = 1'b0; cyc(3);
      m_count = m_count + 32'd1;
      c_ready = 1'b1; cyc(1); c_ready = 1'b0;
      snap_chk("snap_edge_after", 0);

      // counting continues while a snapshot is pending
      snap = 1'b1; cyc(1); snap = 1'b0;
      held = m_count;
      ev(1'b1);
      ev(1'b1);
      chk("valid_count_c", 64'(c), 64'(held));
      c_ready = 1'b1; cyc(1); c_ready = 1'b0;
      snap_chk("valid_count_after", 0);

      // asynchronous reset mid-operation with a snapshot pending and an edge in flight
      ev(1'b1);
      snap = 1'b1; cyc(1); snap = 1'b0;
      a = 1'b1; cyc(1);
      #($urandom_range(1, 7));
      rst_n = 1'b0;
      #1;
      chk("midrst_c", 64'(c), 64'd0);
      chk("midrst_valid", 64'(c_valid), 64'd0);
      chk("midrst_tc", 64'(tc), 64'd0);
      a = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      cyc(2);
      m_count = '0;
      snap_chk("midrst_snap", 1);

      // randomized mix
      for (int it = 0; it < 80; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: ev(1'($urandom_range(0, 1)));
            6, 7:             snap_chk("rnd_snap", $urandom_range(0, 4));
            8:                do_clr();
            default: begin
               c_ready = 1'b1; cyc(1); c_ready = 1'b0;
               chk("rnd_idle_ready", 64'(c_valid), 64'd0);
            end
         endcase
      end
      snap_chk("final_snap", 1);
      chk("tc_single_cycle", 64'(tc_double), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
